seg_scan_driver: RTL and testbench

- Downstream display stage for the two-decade counter. Takes the two BCD digits (units, tens) and drives a multiplexed, common-anode 7-segment display (8 anodes; only the low two are used).
- Time-multiplexes the digits at a programmable per-digit refresh rate.
- Inserts an anode-off guard interval between digits to suppress ghosting.
- Captures the digits once per frame, so a mid-frame change in the counter never produces a torn display.

---
 rtl/seg_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed common-anode 7-segment driver for a two-digit BCD value.
//   It alternates between a units slot and a tens slot. Each slot lasts DIV
//   cycles, where DIV = CLK_HZ/REFRESH_HZ. At the start of each slot every
//   anode stays off for BLANK_CYCLES cycles. Digits and decimal points are
//   captured once per frame, at the start of the units slot, so a value that
//   changes mid-frame never shows up half-updated.
//
//   Optional build macro LEADING_ZERO_BLANK_EN: when defined, a tens digit of
//   0 leaves the tens slot dark. The slot timing does not change.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   digit_lo  units BCD digit
//   digit_hi  tens BCD digit
//   dp_mask   decimal-point enables, bit0 = units, bit1 = tens (active high)
//   seg       segments {g,f,e,d,c,b,a}, active low
//   an        anodes, active low; only an[1:0] are ever driven low
//   dp1       decimal point, active low
//
// Slot FSM
//   state   | meaning
//   SLOT_LO | units digit slot, anode 0
//   SLOT_HI | tens digit slot, anode 1
module seg_scan_driver #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_lo,
  input  logic [3:0] digit_hi,
  input  logic [1:0] dp_mask,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       dp1
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {
    SLOT_LO = 1'b0,
    SLOT_HI = 1'b1
  } slot_t;

  slot_t         slot, slot_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    sh_lo, sh_hi;
  logic [1:0]    sh_dp;
  logic          capture;
  logic          hi_visible;
  logic [6:0]    seg_nxt;
  logic [7:0]    an_nxt;
  logic          dp1_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // dash for non-BCD codes
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  assign hi_visible = (sh_hi != 4'd0);
`else
  assign hi_visible = 1'b1;
`endif

  // Slot state register
  always_ff @(posedge clk) begin
    if (!rst) slot <= SLOT_LO;
    else      slot <= slot_nxt;
  end

  always_comb begin
    cnt_nxt  = cnt + CW'(1);
    slot_nxt = slot;
    if (cnt == CNT_LAST) begin
      cnt_nxt  = '0;
      slot_nxt = (slot == SLOT_LO) ? SLOT_HI : SLOT_LO;
    end

    capture = (slot == SLOT_LO) && (cnt == '0);

    an_nxt  = 8'hFF;
    seg_nxt = 7'h7F;
    dp1_nxt = 1'b1;
    if (cnt >= CNT_BLANK) begin
      case (slot)
        SLOT_LO: begin
          an_nxt  = 8'hFE;
          seg_nxt = decode(sh_lo);
          dp1_nxt = ~sh_dp[0];
        end
        SLOT_HI: begin
          if (hi_visible) begin
            an_nxt  = 8'hFD;
            seg_nxt = decode(sh_hi);
            dp1_nxt = ~sh_dp[1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      sh_lo <= '0;
      sh_hi <= '0;
      sh_dp <= '0;
      seg   <= 7'h7F;
      an    <= 8'hFF;
      dp1   <= 1'b1;
    end else begin
      cnt <= cnt_nxt;
      if (capture) begin
        sh_lo <= digit_lo;
        sh_hi <= digit_hi;
        sh_dp <= dp_mask;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
      dp1 <= dp1_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int CLK_HZ     = 1000;
  localparam int REFRESH_HZ = 100;
  localparam int BLANK      = 2;
  localparam int DIV        = CLK_HZ / REFRESH_HZ;
  localparam int FRAME      = 2 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_lo = '0;
  logic [3:0] digit_hi = '0;
  logic [1:0] dp_mask = '0;
  logic [6:0] seg;
  logic [7:0] an;
  logic       dp1;

  seg_scan_driver #(
    .CLK_HZ(CLK_HZ),
    .REFRESH_HZ(REFRESH_HZ),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_lo(digit_lo),
    .digit_hi(digit_hi),
    .dp_mask(dp_mask),
    .seg(seg),
    .an(an),
    .dp1(dp1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the position within the frame, plus the digits latched for the frame.
  logic [6:0] dec_tab [16];
  int         pos = 0;
  int         m_cnt, m_slot;
  logic [3:0] f_lo = '0, f_hi = '0;
  logic [1:0] f_dp = '0;
  logic [7:0] exp_an  = 8'hFF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp1 = 1'b1;
  logic       lzb = 1'b0;

  // Advance one clock edge and work out what the outputs must be after it.
  task automatic tick();
    @(posedge clk);
    exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp1 = 1'b1;
    if (!rst) begin
      pos = 0; f_lo = '0; f_hi = '0; f_dp = '0;
      m_cnt = 0; m_slot = 0;
    end else begin
      if (pos == 0) begin
        f_lo = digit_lo; f_hi = digit_hi; f_dp = dp_mask;
      end
      m_slot = pos / DIV;
      m_cnt  = pos % DIV;
      if (m_cnt >= BLANK) begin
        if (m_slot == 0) begin
          exp_an = 8'hFE; exp_seg = dec_tab[f_lo]; exp_dp1 = ~f_dp[0];
        end else if (!(lzb && f_hi == 4'd0)) begin
          exp_an = 8'hFD; exp_seg = dec_tab[f_hi]; exp_dp1 = ~f_dp[1];
        end
      end
      pos = (pos + 1) % FRAME;
    end
    #1;
  endtask

  task automatic wait_pos(input int target);
    int k;
    k = 0;
    while (pos != target && k < 2 * FRAME) begin
      tick();
      k++;
    end
    n_checks++;
    if (pos != target) begin
      $display("FAIL wait_pos: reached pos %0d, required %0d", pos, target);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; digit_hi = 4'd7; digit_lo = 4'd3; dp_mask = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({an, seg, dp1} !== {8'hFF, 7'h7F, 1'b1}) begin
        $display("FAIL reset_hold[%0d]: an=%h seg=%b dp1=%b, required an=ff seg=1111111 dp1=1", i, an, seg, dp1);
        n_fail++;
      end
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({an, seg, dp1} !== {8'hFF, 7'h7F, 1'b1}) begin
      $display("FAIL reset_release: an=%h seg=%b dp1=%b, required an=ff seg=1111111 dp1=1", an, seg, dp1);
      n_fail++;
    end
  endtask

  task automatic run_checked(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      n_checks++;
      if ({an, seg, dp1} !== {exp_an, exp_seg, exp_dp1}) begin
        $display("FAIL %s[%0d] slot=%0d cnt=%0d: an=%h seg=%b dp1=%b, required an=%h seg=%b dp1=%b",
                 name, i, m_slot, m_cnt, an, seg, dp1, exp_an, exp_seg, exp_dp1);
        n_fail++;
      end
      n_checks++;
      if ($countones(~an) > 1) begin
        $display("FAIL %s_ghost[%0d]: an=%h, required at most one low anode", name, i, an);
        n_fail++;
      end
    end
  endtask

  task automatic test_normal_scan();
    digit_hi = 4'd0; digit_lo = 4'd3; dp_mask = 2'b00;
    wait_pos(0);
    run_checked("scan", 2 * FRAME);
    // Units slot, cnt 5 of the next frame: digit 3
    wait_pos(6);
    n_checks++;
    if ({an, seg} !== {8'hFE, 7'b0110000}) begin
      $display("FAIL scan_units: an=%h seg=%b, required an=fe seg=0110000", an, seg);
      n_fail++;
    end
  endtask

  task automatic test_tear_free();
    digit_lo = 4'd3; digit_hi = 4'd0; dp_mask = 2'b00;
    wait_pos(0);
    wait_pos(DIV + 5);
    digit_lo = 4'd4;
    for (int i = 0; i < DIV - 5; i++) begin
      tick();
      n_checks++;
      if (an == 8'hFE || seg == 7'b0011001) begin
        $display("FAIL tear_cur[%0d]: an=%h seg=%b, required no units digit 4 in this frame", i, an, seg);
        n_fail++;
      end
    end
    run_checked("tear_next", FRAME);
    wait_pos(4);
    n_checks++;
    if ({an, seg} !== {8'hFE, 7'b0011001}) begin
      $display("FAIL tear_new: an=%h seg=%b, required an=fe seg=0011001", an, seg);
      n_fail++;
    end
  endtask

  task automatic test_invalid_dp();
    digit_lo = 4'hC; digit_hi = 4'd5; dp_mask = 2'b01;
    wait_pos(0);
    run_checked("inv_dp", 2 * FRAME);
    wait_pos(5);
    n_checks++;
    if ({an, seg, dp1} !== {8'hFE, 7'b0111111, 1'b0}) begin
      $display("FAIL inv_units: an=%h seg=%b dp1=%b, required an=fe seg=0111111 dp1=0", an, seg, dp1);
      n_fail++;
    end
    wait_pos(DIV + 5);
    n_checks++;
    if (dp1 !== 1'b1) begin
      $display("FAIL inv_tens_dp: dp1=%b, required 1", dp1);
      n_fail++;
    end
  endtask

  task automatic test_mid_reset();
    int first;
    digit_lo = 4'd8; digit_hi = 4'd2; dp_mask = 2'b10;
    wait_pos(DIV + 6);
    rst = 1'b0;
    tick();
    n_checks++;
    if ({an, seg, dp1} !== {8'hFF, 7'h7F, 1'b1}) begin
      $display("FAIL midrst_blank: an=%h seg=%b dp1=%b, required an=ff seg=1111111 dp1=1", an, seg, dp1);
      n_fail++;
    end
    rst = 1'b1;
    first = -1;
    for (int i = 0; i < DIV; i++) begin
      tick();
      if (first < 0 && an != 8'hFF) begin
        first = i;
        n_checks++;
        if (an !== 8'hFE) begin
          $display("FAIL midrst_first_an: an=%h, required fe", an);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (first != BLANK) begin
      $display("FAIL midrst_first_idx: first lit edge %0d, required %0d", first, BLANK);
      n_fail++;
    end
    run_checked("midrst", FRAME);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        digit_lo = 4'($urandom);
        digit_hi = 4'($urandom);
        dp_mask  = 2'($urandom);
      end
      rst = ($urandom_range(0, 150) != 0);
      run_checked("random", 1);
    end
    rst = 1'b1;
  endtask

  task automatic test_leading_zero();
    digit_hi = 4'd0; digit_lo = 4'd9; dp_mask = 2'b10;
    wait_pos(0);
    run_checked("lz_zero", 2 * FRAME);
    wait_pos(5);
    n_checks++;
    if (seg !== 7'b0010000) begin
      $display("FAIL lz_units: seg=%b, required 0010000", seg);
      n_fail++;
    end
    digit_hi = 4'd1;
    wait_pos(0);
    run_checked("lz_one", FRAME);
    wait_pos(DIV + 5);
    n_checks++;
    if ({an, seg} !== {8'hFD, 7'b1111001}) begin
      $display("FAIL lz_tens_one: an=%h seg=%b, required an=fd seg=1111001", an, seg);
      n_fail++;
    end
  endtask

  initial begin
    dec_tab[0] = 7'b1000000; dec_tab[1] = 7'b1111001; dec_tab[2] = 7'b0100100;
    dec_tab[3] = 7'b0110000; dec_tab[4] = 7'b0011001; dec_tab[5] = 7'b0010010;
    dec_tab[6] = 7'b0000010; dec_tab[7] = 7'b1111000; dec_tab[8] = 7'b0000000;
    dec_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    lzb = 1'b1;
`endif
    test_reset();
    test_normal_scan();
    test_tear_free();
    test_invalid_dp();
    test_mid_reset();
    test_random();
    test_leading_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
